// File: rtl/io_output.sv
// Memory-mapped output ports (0x80/0x84/0x88) with write strobes, readback, and an
// 8-digit multiplexed hex display of port 2. Define IO_OUT_BLANK_EN for leading-zero blanking.
module io_output #(
    parameter int SCAN_DIV_W = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [2:0]  out_strobe,
    output logic [31:0] io_readback,
    output logic [7:0]  seg_an,
    output logic [6:0]  seg_cat
);

    logic [31:0]           port0_q, port0_d;
    logic [31:0]           port1_q, port1_d;
    logic [31:0]           port2_q, port2_d;
    logic [2:0]            strobe_q, strobe_d;
    logic [SCAN_DIV_W-1:0] scan_q, scan_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            seg_an_q, seg_an_d;
    logic [6:0]            seg_cat_q, seg_cat_d;

    logic [2:0]            hit;
    logic [3:0]            nibble;
    logic                  blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        hit = 3'b000;
        case (addr[7:2])
            6'b100000: hit = 3'b001;
            6'b100001: hit = 3'b010;
            6'b100010: hit = 3'b100;
            default:   hit = 3'b000;
        endcase
    end

    always_comb begin
        io_readback = 32'h0;
        case (hit)
            3'b001:  io_readback = port0_q;
            3'b010:  io_readback = port1_q;
            3'b100:  io_readback = port2_q;
            default: io_readback = 32'h0;
        endcase
    end

    always_comb begin
        strobe_d = write_io_enable ? hit : 3'b000;
        port0_d  = strobe_d[0] ? datain : port0_q;
        port1_d  = strobe_d[1] ? datain : port1_q;
        port2_d  = strobe_d[2] ? datain : port2_q;
    end

    // Display path samples the current idx and port2, so it lags both by one cycle.
    always_comb begin
        scan_d    = scan_q + SCAN_DIV_W'(1);
        idx_d     = (&scan_q) ? idx_q + 3'd1 : idx_q;
        nibble    = port2_q[{idx_q, 2'b00} +: 4];
`ifdef IO_OUT_BLANK_EN
        blank     = (idx_q != 3'd0) && ((port2_q >> {idx_q, 2'b00}) == 32'h0);
`else
        blank     = 1'b0;
`endif
        seg_an_d  = blank ? 8'hFF : ~(8'b1 << idx_q);
        seg_cat_d = hex7(nibble);
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            port0_q   <= 32'h0;
            port1_q   <= 32'h0;
            port2_q   <= 32'h0;
            strobe_q  <= 3'b000;
            scan_q    <= '0;
            idx_q     <= 3'd0;
            seg_an_q  <= 8'hFE;
            seg_cat_q <= 7'h40;
        end else begin
            port0_q   <= port0_d;
            port1_q   <= port1_d;
            port2_q   <= port2_d;
            strobe_q  <= strobe_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            seg_an_q  <= seg_an_d;
            seg_cat_q <= seg_cat_d;
        end
    end

    assign out_port0  = port0_q;
    assign out_port1  = port1_q;
    assign out_port2  = port2_q;
    assign out_strobe = strobe_q;
    assign seg_an     = seg_an_q;
    assign seg_cat    = seg_cat_q;

endmodule

// File: tb/tb_io_output.sv
// Directed bench for io_output with a strobe scoreboard: stimulus queues expected writes,
// a negedge monitor pops one entry for every cycle the DUT raises out_strobe.
module tb_io_output;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [2:0]  out_strobe;
    logic [31:0] io_readback;
    logic [7:0]  seg_an;
    logic [6:0]  seg_cat;

    typedef struct packed {
        logic [2:0]  strb;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    io_output #(.SCAN_DIV_W(2)) dut (
        .io_clk(io_clk), .reset(reset), .addr(addr), .datain(datain),
        .write_io_enable(write_io_enable), .out_port0(out_port0), .out_port1(out_port1),
        .out_port2(out_port2), .out_strobe(out_strobe), .io_readback(io_readback),
        .seg_an(seg_an), .seg_cat(seg_cat)
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    // Expected anode pattern for digit k while out_port2 = 0x000000A5.
    function automatic logic [7:0] an_exp(input int k);
        logic [7:0] a;
        case (k)
            0: a = 8'hFE;
            1: a = 8'hFD;
            2: a = 8'hFB;
            3: a = 8'hF7;
            4: a = 8'hEF;
            5: a = 8'hDF;
            6: a = 8'hBF;
            default: a = 8'h7F;
        endcase
`ifdef IO_OUT_BLANK_EN
        if (k >= 2) a = 8'hFF;
`endif
        return a;
    endfunction

    always @(negedge io_clk) begin
        if (out_strobe !== 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'h0, out_strobe}, 32'h0);
            end else begin
                exp_t e;
                logic [31:0] v;
                e = exp_q.pop_front();
                v = out_strobe[0] ? out_port0 : (out_strobe[1] ? out_port1 : out_port2);
                check("sb_strobe", {29'h0, out_strobe}, {29'h0, e.strb});
                check("sb_value", v, e.val);
            end
        end
    end

    initial begin
        reset = 1'b1; addr = 32'h0; datain = 32'h0; write_io_enable = 1'b0;
        step(); step();
        addr = 32'h80; #1;
        check("rst_port0", out_port0, 32'h0);
        check("rst_port1", out_port1, 32'h0);
        check("rst_port2", out_port2, 32'h0);
        check("rst_strobe", {29'h0, out_strobe}, 32'h0);
        check("rst_seg_an", {24'h0, seg_an}, 32'hFE);
        check("rst_seg_cat", {25'h0, seg_cat}, 32'h40);
        check("rst_readback", io_readback, 32'h0);

        reset = 1'b0;
        datain = 32'h12345678; write_io_enable = 1'b1;
        exp_q.push_back({3'b001, 32'h12345678});
        step();
        write_io_enable = 1'b0;
        check("wr0_port0", out_port0, 32'h12345678);
        check("wr0_strobe", {29'h0, out_strobe}, 32'h1);
        check("wr0_readback", io_readback, 32'h12345678);
        step();
        check("wr0_strobe_clear", {29'h0, out_strobe}, 32'h0);

        addr = 32'h84; datain = 32'hDEADBEEF; write_io_enable = 1'b0;
        step();
        check("noen_port1", out_port1, 32'h0);
        addr = 32'h8C; write_io_enable = 1'b1;
        step();
        write_io_enable = 1'b0;
        check("miss_port0", out_port0, 32'h12345678);
        check("miss_port1", out_port1, 32'h0);
        check("miss_port2", out_port2, 32'h0);
        check("miss_readback", io_readback, 32'h0);
        addr = 32'h84; #1;
        check("rb_port1", io_readback, 32'h0);

        reset = 1'b1; datain = 32'hFFFFFFFF; write_io_enable = 1'b1;
        step();
        check("rstwr_port1", out_port1, 32'h0);
        check("rstwr_port0", out_port0, 32'h0);
        check("rstwr_strobe", {29'h0, out_strobe}, 32'h0);

        reset = 1'b0; addr = 32'h88; datain = 32'h000000A5;
        exp_q.push_back({3'b100, 32'h000000A5});
        step();
        write_io_enable = 1'b0;
        check("disp_port2", out_port2, 32'hA5);
        step();
        check("dig0_an", {24'h0, seg_an}, {24'h0, an_exp(0)});
        check("dig0_cat", {25'h0, seg_cat}, 32'h12);
        repeat (3) step();
        check("dig1_an", {24'h0, seg_an}, {24'h0, an_exp(1)});
        check("dig1_cat", {25'h0, seg_cat}, 32'h08);
        for (int k = 2; k < 8; k++) begin
            repeat (4) step();
            check($sformatf("dig%0d_an", k), {24'h0, seg_an}, {24'h0, an_exp(k)});
            check($sformatf("dig%0d_cat", k), {25'h0, seg_cat}, 32'h40);
        end
        repeat (4) step();
        check("wrap_an", {24'h0, seg_an}, 32'hFE);
        check("wrap_cat", {25'h0, seg_cat}, 32'h12);

        repeat (20) step();
        check("dig5_an", {24'h0, seg_an}, {24'h0, an_exp(5)});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midscan_an", {24'h0, seg_an}, 32'hFE);
        check("midscan_cat", {25'h0, seg_cat}, 32'h40);
        check("midscan_port2", out_port2, 32'h0);
        step();
        check("midscan_an2", {24'h0, seg_an}, 32'hFE);

        addr = 32'h88; datain = 32'h1; write_io_enable = 1'b1;
        exp_q.push_back({3'b100, 32'h1});
        step();
        datain = 32'h2;
        exp_q.push_back({3'b100, 32'h2});
        step();
        write_io_enable = 1'b0;
        check("b2b_port2", out_port2, 32'h2);
        check("b2b_strobe", {29'h0, out_strobe}, 32'h4);
        step(); step();
        check("b2b_strobe_clear", {29'h0, out_strobe}, 32'h0);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_output.md
Name: io_output

Overview:
- Memory-mapped output-port block; the write-side counterpart of the CPU's input-port block.
- Sits on the same I/O data bus and decodes the same address window (addr[7:2] = 6'b1000xx).
- Latches CPU store data into three 32-bit output registers. Raises a one-cycle update strobe per port and provides combinational readback.
- Drives an 8-digit multiplexed 7-segment display that shows out_port2 in hex.

Parameters:
- SCAN_DIV_W, 16, width of the free-running scan prescaler; the digit advances every 2^SCAN_DIV_W clocks.

Ports:
- io_clk  input  1  sole clock; every register updates on its rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  32  CPU byte address; only addr[7:2] is decoded
- datain  input  32  CPU store data
- write_io_enable  input  1  store-to-I/O qualifier
- out_port0  output  32  port 0 register (addr 0x80)
- out_port1  output  32  port 1 register (addr 0x84)
- out_port2  output  32  port 2 register (addr 0x88), also the display source
- out_strobe  output  3  bit i = one-cycle pulse when port i was written
- io_readback  output  32  combinational readback of the port selected by addr[7:2]
- seg_an  output  8  digit anodes, active-low, bit i = digit i
- seg_cat  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Decode of addr[7:2]:
  - 6'b100000 → port0
  - 6'b100001 → port1
  - 6'b100010 → port2
  - any other value → no hit
- Write: on the io_clk edge where write_io_enable=1 and decode hits port i, out_port i <= datain. Other ports hold.
- Strobe: out_strobe[i] is registered. It is 1 in exactly the cycle after the write edge, i.e. the same cycle the new value first appears, and 0 otherwise. A back-to-back write to the same port holds it high for consecutive cycles.
- Writes that miss the decode, or have write_io_enable=0, change nothing and produce no strobe.
- io_readback: pure combinational mux of the port registers by addr[7:2]; 32'h0 on a miss. Independent of write_io_enable.
- Scan counter (SCAN_DIV_W bits):
  - Free-running, increments every clock.
  - On wrap from all-ones to 0, the 3-bit digit index idx increments; 7 wraps to 0.
- Display outputs are registered, one cycle behind idx / out_port2:
  - seg_an <= ~(8'b1 << idx)
  - seg_cat <= hex7(out_port2[4*idx+3 : 4*idx])
- hex7 table, active-low gfedcba, values 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Reset (synchronous, dominant over any simultaneous write):
  - all ports 0, out_strobe 0, scan counter 0, idx 0
  - seg_an=8'hFE, seg_cat=7'h40
- Reset mid-scan: the next cycle is identical to the post-reset state; there is no partial digit.
- Write to port2 while a digit is displayed: the new nibble appears on seg_cat one cycle after out_port2 updates. The scan phase is unaffected.

Optional Feature:
- Macro IO_OUT_BLANK_EN enables leading-zero blanking.
- With the macro defined: digit i (i>=1) is blanked when out_port2[31:4*i] == 0. Blanked means its seg_an bit stays 1 when selected, so all anodes are off that slot. Digit 0 is never blanked. Scan timing is unchanged.
- Without the macro: all 8 digits are always driven.
- Reset values are identical in both builds.

Test Plan:
- Reset: assert reset 2 cycles → all ports 0, out_strobe 0, seg_an=FE, seg_cat=40, io_readback(addr 0x80)=0.
- Write port0: addr=0x80, datain=0x12345678, write_io_enable=1 for one edge → out_port0=0x12345678 next cycle, out_strobe=3'b001 for exactly one cycle, io_readback(addr 0x80)=0x12345678.
- Rejected writes: addr=0x84, enable=0, datain=0xDEADBEEF → out_port1 stays 0, no strobe. Then addr=0x8C with enable=1 → no port changes, io_readback(0x8C)=0.
- Display scan (SCAN_DIV_W=2): write port2=0x000000A5 → digit0 slot shows seg_an=FE, seg_cat=12. Digit1 slot (4 clocks later) shows seg_an=FD, seg_cat=08. Digit7 shows 40 (blanked slot with IO_OUT_BLANK_EN). idx wraps 7→0.
- Simultaneous reset and write to port1 (0xFFFFFFFF) → out_port1=0, no strobe. Reset at idx=5 → next cycle seg_an=FE.
- Back-to-back writes to port2 on 2 consecutive edges (0x1, 0x2) → out_strobe[2] high 2 cycles, final out_port2=0x2.
